alu_issue_ctrl: RTL and testbench

- Registered issue/capture stage that wraps the combinational ALU.
- Accepts operation requests over a valid/ready handshake and holds operands and Sel stable on the ALU inputs for one execute cycle.
- Captures Rout/Overout into a result register and presents the result downstream over valid/ready.
- Also keeps an accumulator for chained operations, a sticky overflow flag and an operation counter.

---
 rtl/alu_issue_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Registered issue/capture stage wrapped around a purely combinational ALU.
// A request is accepted over a valid/ready handshake. Its operands and function
// select are then held stable on the ALU inputs for one execute cycle. The
// ALU result is captured into a result register and offered downstream over
// valid/ready. The block also keeps an accumulator for chained operations, a
// sticky overflow flag and a completed-operation counter.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     request valid
//   in_ready     block can accept a request this cycle
//   in_a, in_b   operands (WIDTH)
//   in_sel       ALU function select, passed through unchanged (3)
//   in_acc       1 = use accumulator as operand A instead of in_a
//   alu_a/alu_b  registered operands driven to the ALU (WIDTH)
//   alu_sel      registered function select driven to the ALU (3)
//   alu_r        ALU result (WIDTH)
//   alu_over     ALU overflow
//   out_valid    captured result valid
//   out_ready    downstream accepts the result
//   out_r        captured result (WIDTH)
//   out_over     captured overflow for this result
//   acc          accumulator (last captured result)
//   sticky_over  set by any captured overflow, held until cleared
//   clr_sticky   clears sticky_over (a coincident overflow capture wins)
//   op_count     number of captured results, modulo 2^CNTW
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_sel,
    input  logic             in_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_over,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_over,
    output logic [WIDTH-1:0] acc,
    output logic             sticky_over,
    input  logic             clr_sticky,
    output logic [CNTW-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] alu_a_reg;
    logic [WIDTH-1:0] alu_b_reg;
    logic [2:0]       alu_sel_reg;
    logic [WIDTH-1:0] out_r_reg;
    logic             out_over_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             sticky_over_reg;
    logic [CNTW-1:0]  op_count_reg;

    logic accept;
    logic capture;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // The ALU is combinational, so one cycle is always enough.
                state_next = HOLD;
            end
            HOLD: begin
                // Retiring and accepting on the same edge keeps the
                // pipeline at one operation every two cycles.
                if (out_ready) begin
                    state_next = in_valid ? EXEC : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
            end
            EXEC: begin
                in_ready = 1'b0;
            end
            HOLD: begin
                out_valid = 1'b1;
                // A new request may enter only as the held result leaves.
                in_ready  = out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign capture = (state_reg == EXEC);

    // ------------------------------------------------------------------
    // Operand, result, accumulator, sticky flag and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
            alu_sel_reg     <= '0;
            out_r_reg       <= '0;
            out_over_reg    <= 1'b0;
            acc_reg         <= '0;
            sticky_over_reg <= 1'b0;
            op_count_reg    <= '0;
        end else begin
            // Operands change only on accept so the ALU inputs stay stable
            // through EXEC and HOLD. On a HOLD retire/accept edge acc_reg
            // already holds the retiring result, so chaining picks it up.
            if (accept) begin
                alu_a_reg   <= in_acc ? acc_reg : in_a;
                alu_b_reg   <= in_b;
                alu_sel_reg <= in_sel;
            end

            if (capture) begin
                out_r_reg    <= alu_r;
                out_over_reg <= alu_over;
                acc_reg      <= alu_r;
                op_count_reg <= op_count_reg + CNTW'(1);
            end

            // A coincident overflow capture takes priority over a clear.
            if (capture && alu_over) begin
                sticky_over_reg <= 1'b1;
            end else if (clr_sticky) begin
                sticky_over_reg <= 1'b0;
            end
        end
    end

    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_sel     = alu_sel_reg;
    assign out_r       = out_r_reg;
    assign out_over    = out_over_reg;
    assign acc         = acc_reg;
    assign sticky_over = sticky_over_reg;
    assign op_count    = op_count_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Bench for alu_issue_ctrl with a small behavioural ALU on the alu_* side.
// The ALU functions are: 000 add with carry out as overflow, 001 subtract
// with borrow as overflow, 010 and, 011 or, 100 xor, others pass A.
// A vector table holds hand-computed results. Each accepted request pushes
// its expected result to a scoreboard queue. A negedge monitor pops and
// compares on every retire (out_valid && out_ready).
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int WIDTH = 4;
    localparam int CNTW  = 8;
    localparam int NVEC  = 10;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_sel;
    logic             in_acc;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_r;
    logic             alu_over;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_r;
    logic             out_over;
    logic [WIDTH-1:0] acc;
    logic             sticky_over;
    logic             clr_sticky;
    logic [CNTW-1:0]  op_count;

    alu_issue_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .in_acc     (in_acc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_r      (alu_r),
        .alu_over   (alu_over),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_over   (out_over),
        .acc        (acc),
        .sticky_over(sticky_over),
        .clr_sticky (clr_sticky),
        .op_count   (op_count)
    );

    // Behavioural stand-in for the combinational ALU.
    always_comb begin
        alu_r    = alu_a;
        alu_over = 1'b0;
        case (alu_sel)
            3'b000:  {alu_over, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  {alu_over, alu_r} = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  alu_r = alu_a & alu_b;
            3'b011:  alu_r = alu_a | alu_b;
            3'b100:  alu_r = alu_a ^ alu_b;
            default: alu_r = alu_a;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       sel;
        logic             use_acc;
        logic [WIDTH-1:0] exp_alu_a;
        logic [WIDTH-1:0] exp_r;
        logic             exp_over;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             over;
    } res_t;

    vec_t vec [NVEC];
    res_t sb [$];

    int total = 0;
    int bad   = 0;
    int last_accept_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", name, act, $time);
        end
    endtask

    // Scoreboard consumer: a retire happens on the edge after this negedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_retire: got result %0h with nothing expected", out_r);
            end else begin
                res_t e;
                e = sb.pop_front();
                if (out_r !== e.r || out_over !== e.over) begin
                    bad++;
                    $display("FAIL sb_retire: got r=%0h over=%0b expected r=%0h over=%0b",
                             out_r, out_over, e.r, e.over);
                end else begin
                    $display("ok   sb_retire: r=%0h over=%0b", out_r, out_over);
                end
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request and wait (bounded) for the accept edge. Returns
    // 1 time unit after that edge with in_valid still asserted.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] sel, input logic use_acc,
                         input logic [WIDTH-1:0] er, input logic eo);
        res_t e;
        bit   got;
        in_a     = a;
        in_b     = b;
        in_sel   = sel;
        in_acc   = use_acc;
        in_valid = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 50 cycles");
        end else begin
            e.r  = er;
            e.over = eo;
            sb.push_back(e);
            last_accept_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        sb.delete();
    endtask

    int prev_cyc;

    initial begin
        // Stimulus table: hand-computed against the ALU functions above.
        vec[0] = '{4'h3, 4'h4, 3'b000, 1'b0, 4'h3, 4'h7, 1'b0};
        vec[1] = '{4'h9, 4'h7, 3'b000, 1'b0, 4'h9, 4'h0, 1'b1};
        vec[2] = '{4'h1, 4'h1, 3'b000, 1'b0, 4'h1, 4'h2, 1'b0};
        vec[3] = '{4'h2, 4'h3, 3'b000, 1'b0, 4'h2, 4'h5, 1'b0};
        vec[4] = '{4'h0, 4'h6, 3'b000, 1'b1, 4'h5, 4'hB, 1'b0};
        vec[5] = '{4'h0, 4'h6, 3'b000, 1'b1, 4'hB, 4'h1, 1'b1};
        vec[6] = '{4'hC, 4'hA, 3'b010, 1'b0, 4'hC, 4'h8, 1'b0};
        vec[7] = '{4'h0, 4'h3, 3'b011, 1'b1, 4'h8, 4'hB, 1'b0};
        vec[8] = '{4'h5, 4'h7, 3'b001, 1'b0, 4'h5, 4'hE, 1'b1};
        vec[9] = '{4'h0, 4'hF, 3'b100, 1'b1, 4'hE, 4'h1, 1'b0};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_sel     = '0;
        in_acc     = 1'b0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        step(3);

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_over", out_over, 0);
        check("rst_acc", acc, 0);
        check("rst_sticky", sticky_over, 0);
        check("rst_op_count", op_count, 0);
        rst = 1'b0;
        step(1);

        // First add and latency: EXEC after accept, HOLD after the next edge.
        issue(4'h3, 4'h4, 3'b000, 1'b0, 4'h7, 1'b0);
        in_valid = 1'b0;
        check("lat_exec_out_valid", out_valid, 0);
        check("lat_exec_in_ready", in_ready, 0);
        check("lat_alu_a", alu_a, 3);
        check("lat_alu_b", alu_b, 4);
        step(1);
        check("lat_hold_out_valid", out_valid, 1);
        check("add_out_r", out_r, 7);
        check("add_out_over", out_over, 0);
        check("add_acc", acc, 7);
        check("add_op_count", op_count, 1);
        step(1);
        check("retire_idle_out_valid", out_valid, 0);

        // Table, issued back to back with out_ready=1 and in_valid held high.
        do_reset();
        step(1);
        for (int i = 0; i < NVEC; i++) begin
            prev_cyc = last_accept_cyc;
            issue(vec[i].a, vec[i].b, vec[i].sel, vec[i].use_acc, vec[i].exp_r, vec[i].exp_over);
            check($sformatf("vec%0d_alu_a", i), alu_a, vec[i].exp_alu_a);
            check($sformatf("vec%0d_alu_b", i), alu_b, vec[i].b);
            check($sformatf("vec%0d_alu_sel", i), alu_sel, vec[i].sel);
            if (i > 0) check($sformatf("vec%0d_spacing", i), last_accept_cyc - prev_cyc, 2);
        end
        in_valid = 1'b0;
        step(3);
        check("tbl_op_count", op_count, NVEC);
        check("tbl_sticky", sticky_over, 1);
        check("tbl_acc", acc, 4'h1);

        // Sticky overflow and clear
        do_reset();
        issue(4'h9, 4'h7, 3'b000, 1'b0, 4'h0, 1'b1);
        in_valid = 1'b0;
        step(1);
        check("ovf_out_r", out_r, 0);
        check("ovf_out_over", out_over, 1);
        check("ovf_sticky", sticky_over, 1);
        step(1);
        issue(4'h1, 4'h1, 3'b000, 1'b0, 4'h2, 1'b0);
        in_valid = 1'b0;
        step(1);
        check("noovf_out_over", out_over, 0);
        check("noovf_sticky_held", sticky_over, 1);
        step(1);
        clr_sticky = 1'b1;
        step(1);
        clr_sticky = 1'b0;
        check("clr_sticky", sticky_over, 0);
        check("clr_keeps_count", op_count, 2);

        // Clear coinciding with an overflowing capture: set wins.
        issue(4'h9, 4'h7, 3'b000, 1'b0, 4'h0, 1'b1);
        in_valid   = 1'b0;
        clr_sticky = 1'b1;
        step(1);
        clr_sticky = 1'b0;
        check("clr_vs_set_sticky", sticky_over, 1);
        step(1);

        // Backpressure: held result, pending request, no accept.
        out_ready = 1'b0;
        issue(4'h2, 4'h3, 3'b000, 1'b0, 4'h5, 1'b0);
        in_valid = 1'b0;
        step(1);
        in_a     = 4'h4;
        in_b     = 4'h4;
        in_sel   = 3'b000;
        in_acc   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("bp%0d_in_ready", i), in_ready, 0);
            check($sformatf("bp%0d_out_r", i), out_r, 5);
            check($sformatf("bp%0d_alu_a", i), alu_a, 2);
        end
        out_ready = 1'b1;
        prev_cyc  = cyc;
        issue(4'h4, 4'h4, 3'b000, 1'b0, 4'h8, 1'b0);
        in_valid = 1'b0;
        check("bp_same_edge_accept", last_accept_cyc - prev_cyc, 1);
        check("bp_new_alu_a", alu_a, 4);
        check("bp_exec_out_valid", out_valid, 0);
        step(3);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) begin
            issue(4'h0, 4'h0, 3'b000, 1'b0, 4'h0, 1'b0);
        end
        in_valid = 1'b0;
        step(3);
        check("wrap_op_count_255", op_count, 255);
        issue(4'h0, 4'h0, 3'b000, 1'b0, 4'h0, 1'b0);
        in_valid = 1'b0;
        step(3);
        check("wrap_op_count_0", op_count, 0);

        // Reset during EXEC discards the request.
        do_reset();
        issue(4'h2, 4'h3, 3'b000, 1'b0, 4'h5, 1'b0);
        in_valid = 1'b0;
        step(3);
        check("pre_rst_acc", acc, 5);
        issue(4'h6, 4'h1, 3'b000, 1'b0, 4'h7, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        sb.delete();
        check("rst_exec_out_valid", out_valid, 0);
        check("rst_exec_in_ready", in_ready, 1);
        check("rst_exec_acc", acc, 0);
        check("rst_exec_op_count", op_count, 0);
        check("rst_exec_out_r", out_r, 0);
        check("rst_exec_alu_a", alu_a, 0);
        step(2);
        check("rst_exec_no_capture", op_count, 0);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
